// File: rtl/dram_arb_ctrl.sv
// Two-port controller and round-robin arbiter for a 16-bit, 1M-word asynchronous DRAM.
// Port 0 (video) and port 1 (CPU) share the array. CAS-before-RAS refresh is inserted
// at a fixed period. Every DRAM strobe, address and data-enable comes straight from a flop.
// The address split assumes AW=20: row = addr[9:0], column = addr[19:10].
module dram_arb_ctrl #(
  parameter int REF_PERIOD = 78,
  parameter int AW         = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ref_en,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic          p0_we,
  input  logic [1:0]    p0_be,
  input  logic [15:0]   p0_wdata,
  output logic          p0_ack,
  output logic [15:0]   p0_rdata,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic          p1_we,
  input  logic [1:0]    p1_be,
  input  logic [15:0]   p1_wdata,
  output logic          p1_ack,
  output logic [15:0]   p1_rdata,
  output logic [9:0]    dram_ma,
  inout  wire  [15:0]   dram_d,
  output logic          dram_ras_n,
  output logic          dram_ucas_n,
  output logic          dram_lcas_n,
  output logic          dram_we_n
);

  localparam int              CW         = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CW-1:0]   REF_RELOAD = CW'(REF_PERIOD - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RAS, S_COL, S_CAS1, S_CAS2, S_PRE, S_RF1, S_RF2, S_RF3
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_ref_cnt;
  logic           r_ref_pend;
  logic           r_rr_last;

  // Latched request, held for the whole access
  logic           r_port;
  logic [AW-1:0]  r_addr;
  logic           r_we;
  logic [1:0]     r_be;
  logic [15:0]    r_wdata;

  // Registered DRAM pins and client outputs
  logic [9:0]     r_ma;
  logic           r_ras_n;
  logic           r_ucas_n;
  logic           r_lcas_n;
  logic           r_we_n;
  logic           r_d_oe;
  logic           r_p0_ack;
  logic           r_p1_ack;
  logic [15:0]    r_p0_rdata;
  logic [15:0]    r_p1_rdata;

  // Arbitration: port 1 wins when it is the only requester, or on a tie when port 0 went last.
  logic           w_arb_state;
  logic           w_any_req;
  logic           w_pick_p1;
  logic           w_grant;
  logic           w_ref_expire;

  assign w_arb_state  = (r_state == S_IDLE) || (r_state == S_PRE);
  assign w_any_req    = p0_req | p1_req;
  assign w_pick_p1    = p1_req & (~p0_req | ~r_rr_last);
  assign w_grant      = w_arb_state & ~r_ref_pend & w_any_req;
  assign w_ref_expire = ref_en && (r_ref_cnt == '0);

  // Refresh interval counter: frozen while ref_en is low, reloads on expiry
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= REF_RELOAD;
    end else if (ref_en) begin
      r_ref_cnt <= (r_ref_cnt == '0) ? REF_RELOAD : r_ref_cnt - 1'b1;
    end
  end

  // Capture the granted request's address, direction, byte enables and data
  // NOTE: these datapath flops have no reset; they are always loaded by a grant before use.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_port  <= w_pick_p1;
      r_addr  <= w_pick_p1 ? p1_addr  : p0_addr;
      r_we    <= w_pick_p1 ? p1_we    : p0_we;
      r_be    <= w_pick_p1 ? p1_be    : p0_be;
      r_wdata <= w_pick_p1 ? p1_wdata : p0_wdata;
    end
  end

  // Main sequencer: arbitration, access and CBR refresh, with registered pin values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ref_pend <= 1'b0;
      r_rr_last  <= 1'b1;
      r_ma       <= '0;
      r_ras_n    <= 1'b1;
      r_ucas_n   <= 1'b1;
      r_lcas_n   <= 1'b1;
      r_we_n     <= 1'b1;
      r_d_oe     <= 1'b0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;

      case (r_state)
        S_IDLE, S_PRE: begin
          if (r_ref_pend) begin
            // CAS drops a clock ahead of RAS, which the DRAM decodes as refresh
            r_state    <= S_RF1;
            r_ref_pend <= 1'b0;
            r_ras_n    <= 1'b1;
            r_ucas_n   <= 1'b0;
            r_lcas_n   <= 1'b0;
            r_we_n     <= 1'b1;
            r_d_oe     <= 1'b0;
          end else if (w_any_req) begin
            r_state   <= S_RAS;
            r_rr_last <= w_pick_p1;
            r_ras_n   <= 1'b0;
            r_ma      <= w_pick_p1 ? p1_addr[9:0] : p0_addr[9:0];
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RAS: begin
          r_state <= S_COL;
          r_ma    <= r_addr[19:10];
          r_we_n  <= ~r_we;
          r_d_oe  <= r_we;
        end

        S_COL: begin
          // Reads strobe both bytes; writes strobe only the enabled lanes
          r_state  <= S_CAS1;
          r_ucas_n <= r_we ? ~r_be[1] : 1'b0;
          r_lcas_n <= r_we ? ~r_be[0] : 1'b0;
        end

        S_CAS1: begin
          r_state <= S_CAS2;
        end

        S_CAS2: begin
          r_state  <= S_PRE;
          r_ras_n  <= 1'b1;
          r_ucas_n <= 1'b1;
          r_lcas_n <= 1'b1;
          r_we_n   <= 1'b1;
          r_d_oe   <= 1'b0;
          if (r_port) begin
            r_p1_ack <= 1'b1;
            if (!r_we) r_p1_rdata <= dram_d;
          end else begin
            r_p0_ack <= 1'b1;
            if (!r_we) r_p0_rdata <= dram_d;
          end
        end

        S_RF1: begin
          r_state <= S_RF2;
          r_ras_n <= 1'b0;
        end

        S_RF2: begin
          r_state <= S_RF3;
        end

        S_RF3: begin
          r_state  <= S_PRE;
          r_ras_n  <= 1'b1;
          r_ucas_n <= 1'b1;
          r_lcas_n <= 1'b1;
          r_we_n   <= 1'b1;
        end

        default: begin
          r_state  <= S_IDLE;
          r_ras_n  <= 1'b1;
          r_ucas_n <= 1'b1;
          r_lcas_n <= 1'b1;
          r_we_n   <= 1'b1;
          r_d_oe   <= 1'b0;
        end
      endcase

      // An expiry on the same edge as a grant still leaves refresh pending
      if (w_ref_expire) r_ref_pend <= 1'b1;
    end
  end

  assign dram_ma     = r_ma;
  assign dram_ras_n  = r_ras_n;
  assign dram_ucas_n = r_ucas_n;
  assign dram_lcas_n = r_lcas_n;
  assign dram_we_n   = r_we_n;
  assign dram_d      = r_d_oe ? r_wdata : 16'hzzzz;
  assign p0_ack      = r_p0_ack;
  assign p1_ack      = r_p1_ack;
  assign p0_rdata    = r_p0_rdata;
  assign p1_rdata    = r_p1_rdata;

endmodule

// File: tb/tb_dram_arb_ctrl.sv
// Directed bench for dram_arb_ctrl with a behavioural asynchronous DRAM on the pins.
module tb_dram_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ref_en;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [19:0] p0_addr, p1_addr;
  logic [1:0]  p0_be, p1_be;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [9:0]  dram_ma;
  wire  [15:0] dram_d;
  logic        dram_ras_n, dram_ucas_n, dram_lcas_n, dram_we_n;

  int errors = 0;
  int checks = 0;

  dram_arb_ctrl #(.REF_PERIOD(20), .AW(20)) dut (
    .clk(clk), .rst(rst), .ref_en(ref_en),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_be(p0_be),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_be(p1_be),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .dram_ma(dram_ma), .dram_d(dram_d), .dram_ras_n(dram_ras_n),
    .dram_ucas_n(dram_ucas_n), .dram_lcas_n(dram_lcas_n), .dram_we_n(dram_we_n)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural DRAM ----------------
  logic [15:0] mem [logic [19:0]];
  logic [9:0]  m_row = '0;
  logic [9:0]  m_col = '0;
  logic [15:0] m_q = '0;
  bit          m_cbr = 1'b0;
  logic        m_oe;
  int          ucas_falls = 0;
  int          lcas_falls = 0;
  int          cbr_cnt = 0;
  int          inv_bad = 0;

  function automatic logic [15:0] m_peek(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic m_write(input bit upper);
    logic [19:0] a;
    logic [15:0] w;
    a = {m_col, m_row};
    w = m_peek(a);
    if (upper) w[15:8] = dram_d[15:8];
    else       w[7:0]  = dram_d[7:0];
    mem[a] = w;
  endtask

  always @(negedge dram_ras_n) begin
    if (!dram_ucas_n || !dram_lcas_n) begin
      m_cbr = 1'b1;
      cbr_cnt++;
    end else begin
      m_cbr = 1'b0;
      m_row = dram_ma;
    end
  end

  always @(posedge dram_ras_n) m_cbr = 1'b0;

  always @(negedge dram_ucas_n) begin
    ucas_falls++;
    if (!dram_ras_n) begin
      m_col = dram_ma;
      if (!dram_we_n) m_write(1'b1);
      else            m_q = m_peek({dram_ma, m_row});
    end
  end

  always @(negedge dram_lcas_n) begin
    lcas_falls++;
    if (!dram_ras_n) begin
      m_col = dram_ma;
      if (!dram_we_n) m_write(1'b0);
      else            m_q = m_peek({dram_ma, m_row});
    end
  end

  assign m_oe   = !dram_ras_n && !m_cbr && dram_we_n && (!dram_ucas_n || !dram_lcas_n);
  assign dram_d = m_oe ? m_q : 16'hzzzz;

  // A released bus reads all-Z in four-state simulators and zero in two-state ones
  function automatic bit undriven(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // The controller must leave dram_d alone whenever we_n is high
  always @(negedge clk) begin
    if (dram_we_n && !m_oe && !undriven(dram_d)) inv_bad++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold it until ack (bounded), then drop it
  task automatic run_req(input bit port, input logic [19:0] addr, input logic we,
                         input logic [1:0] be, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rd);
    lat = 99;
    rd  = 16'h0;
    if (port) begin
      p1_addr = addr; p1_we = we; p1_be = be; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_addr = addr; p0_we = we; p0_be = be; p0_wdata = wdata; p0_req = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      tick;
      if ((port && p1_ack) || (!port && p0_ack)) begin
        lat = i;
        break;
      end
    end
    rd = port ? p1_rdata : p0_rdata;
    if (port) p1_req = 1'b0;
    else      p0_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          lat;
    logic [15:0] rd;
    int          u0, l0, cb0, acks, ras_at_22;
    int          t_cbr [3];
    int          n_cbr;
    logic [31:0] v0, v1, vc;
    logic        prev_lcas;

    rst = 1'b1; ref_en = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p0_we = 1'b0; p0_be = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_addr = '0; p1_we = 1'b0; p1_be = '0; p1_wdata = '0;
    tick; tick;

    // Reset state
    check("rst_ras_n",  32'(dram_ras_n), 32'd1);
    check("rst_ucas_n", 32'(dram_ucas_n), 32'd1);
    check("rst_lcas_n", 32'(dram_lcas_n), 32'd1);
    check("rst_we_n",   32'(dram_we_n), 32'd1);
    check("rst_ma",     32'(dram_ma), 32'd0);
    check("rst_acks",   32'({p0_ack, p1_ack}), 32'd0);
    check("rst_rdata",  32'({p0_rdata, p1_rdata}), 32'd0);
    check("rst_d_z",    32'(undriven(dram_d)), 32'd1);
    rst = 1'b0;
    tick;

    // Port 0 full write, phase by phase
    p0_addr = 20'h12345; p0_we = 1'b1; p0_be = 2'b11; p0_wdata = 16'hBEEF; p0_req = 1'b1;
    tick;
    check("wr_ras_n", 32'(dram_ras_n), 32'd0);
    check("wr_row_ma", 32'(dram_ma), 32'h345);
    tick;
    check("wr_col_ma", 32'(dram_ma), 32'h048);
    check("wr_col_we_n", 32'(dram_we_n), 32'd0);
    check("wr_col_d", 32'(dram_d), 32'hBEEF);
    tick;
    check("wr_cas1", 32'({dram_ucas_n, dram_lcas_n}), 32'd0);
    tick;
    check("wr_cas2_noack", 32'(p0_ack), 32'd0);
    tick;
    check("wr_ack5", 32'(p0_ack), 32'd1);
    check("wr_pre_ras_n", 32'(dram_ras_n), 32'd1);
    p0_req = 1'b0;
    check("wr_mem", 32'(m_peek(20'h12345)), 32'hBEEF);
    tick;
    check("wr_ack_pulse", 32'(p0_ack), 32'd0);

    // Port 1 reads the word back
    run_req(1'b1, 20'h12345, 1'b0, 2'b11, 16'h0, lat, rd);
    check("rd_lat", 32'(lat), 32'd5);
    check("rd_data", 32'(rd), 32'hBEEF);
    check("wr_keeps_p0_rdata", 32'(p0_rdata), 32'd0);

    // Low byte only
    u0 = ucas_falls; l0 = lcas_falls;
    run_req(1'b0, 20'h12345, 1'b1, 2'b01, 16'h00AA, lat, rd);
    check("be01_lat", 32'(lat), 32'd5);
    check("be01_lcas_fall", 32'(lcas_falls - l0), 32'd1);
    check("be01_ucas_fall", 32'(ucas_falls - u0), 32'd0);
    run_req(1'b1, 20'h12345, 1'b0, 2'b11, 16'h0, lat, rd);
    check("be01_readback", 32'(rd), 32'hBEAA);

    // No byte enables: full timing, no CAS
    u0 = ucas_falls; l0 = lcas_falls;
    run_req(1'b0, 20'h12345, 1'b1, 2'b00, 16'h1234, lat, rd);
    check("be00_lat", 32'(lat), 32'd5);
    check("be00_no_cas", 32'((ucas_falls - u0) + (lcas_falls - l0)), 32'd0);
    run_req(1'b1, 20'h12345, 1'b0, 2'b11, 16'h0, lat, rd);
    check("be00_unchanged", 32'(rd), 32'hBEAA);

    // Both ports held high: port 1 went last, so port 0 starts and grants alternate
    p0_addr = 20'h00010; p0_we = 1'b0; p0_be = 2'b11;
    p1_addr = 20'h00020; p1_we = 1'b0; p1_be = 2'b11;
    p0_req = 1'b1; p1_req = 1'b1;
    v0 = '0; v1 = '0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      v0[i] = p0_ack;
      v1[i] = p1_ack;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check("rr_p0_acks", v0, 32'h0000_8020);
    check("rr_p1_acks", v1, 32'h0010_0400);
    tick; tick;

    // Idle refresh with period 20
    rst = 1'b1; tick; rst = 1'b0;
    ref_en = 1'b1;
    cb0 = cbr_cnt; acks = 0; n_cbr = 0; prev_lcas = dram_lcas_n; ras_at_22 = 9;
    t_cbr[0] = 0; t_cbr[1] = 0; t_cbr[2] = 0;
    for (int i = 1; i <= 62; i++) begin
      tick;
      if (prev_lcas && !dram_lcas_n && dram_ras_n && n_cbr < 3) begin
        t_cbr[n_cbr] = i;
        n_cbr++;
      end
      if (i == 22) ras_at_22 = 32'(dram_ras_n);
      if (p0_ack || p1_ack) acks++;
      prev_lcas = dram_lcas_n;
    end
    check("ref_first", 32'(t_cbr[0]), 32'd21);
    check("ref_second", 32'(t_cbr[1]), 32'd41);
    check("ref_third", 32'(t_cbr[2]), 32'd61);
    check("ref_ras_after_cas", 32'(ras_at_22), 32'd0);
    check("ref_model_cbr", 32'(cbr_cnt - cb0), 32'd3);
    check("ref_no_ack", 32'(acks), 32'd0);

    // Refresh while both ports stay busy: inserted at the first PRE after expiry
    ref_en = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    ref_en = 1'b1;
    p0_addr = 20'h12345; p1_addr = 20'h12345;
    p0_req = 1'b1; p1_req = 1'b1;
    v0 = '0; v1 = '0; vc = '0; prev_lcas = dram_lcas_n;
    for (int i = 1; i <= 30; i++) begin
      tick;
      v0[i] = p0_ack;
      v1[i] = p1_ack;
      vc[i] = prev_lcas && !dram_lcas_n && dram_ras_n;
      prev_lcas = dram_lcas_n;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    ref_en = 1'b0;
    check("busy_p0_acks", v0, 32'h2000_8020);
    check("busy_p1_acks", v1, 32'h0010_0400);
    check("busy_cbr", vc, 32'h0020_0000);
    check("busy_p0_rdata", 32'(p0_rdata), 32'hBEAA);
    for (int i = 0; i < 6; i++) tick;
    check("busy_p1_rdata", 32'(p1_rdata), 32'hBEAA);

    // Reset during CAS2 of a read
    rst = 1'b1; tick; rst = 1'b0; tick;
    p1_addr = 20'h12345; p1_we = 1'b0; p1_be = 2'b11; p1_req = 1'b1;
    tick; tick; tick; tick;
    check("mid_cas2_low", 32'({dram_ucas_n, dram_lcas_n, dram_ras_n}), 32'd0);
    rst = 1'b1;
    tick;
    check("mid_rst_strobes", 32'({dram_ras_n, dram_ucas_n, dram_lcas_n, dram_we_n}), 32'hF);
    check("mid_rst_noack", 32'(p1_ack), 32'd0);
    check("mid_rst_rdata", 32'(p1_rdata), 32'd0);
    check("mid_rst_d_z", 32'(undriven(dram_d)), 32'd1);
    rst = 1'b0;
    run_req(1'b1, 20'h12345, 1'b0, 2'b11, 16'h0, lat, rd);
    check("after_rst_lat", 32'(lat), 32'd5);
    check("after_rst_data", 32'(rd), 32'hBEAA);

    tick;
    check("bus_release", 32'(inv_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_arb_ctrl.md
Name: dram_arb_ctrl

Overview:
Two-port DRAM controller and arbiter for the 16-bit-wide, 1M-word asynchronous DRAM.
- Shares the DRAM between port 0 (video fetch) and port 1 (CPU) using round-robin arbitration.
- Sequences RAS/CAS/WE and the multiplexed 10-bit address.
- Inserts CAS-before-RAS refresh at a fixed period.
- Sits between the memory clients and the DRAM pins; all DRAM strobes are driven from flops.

Parameters:
REF_PERIOD, 78, clocks between refresh requests (counter reload value is REF_PERIOD-1).
AW, 20, word address width (row = addr[9:0], column = addr[19:10]).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
ref_en  in  1  enables refresh counter/requests
p0_req  in  1  port 0 request; held until p0_ack
p0_addr  in  20  port 0 word address
p0_we  in  1  1=write, 0=read
p0_be  in  2  byte enables, [1]=d[15:8], [0]=d[7:0]
p0_wdata  in  16  write data
p0_ack  out  1  one-cycle completion pulse
p0_rdata  out  16  read data, valid when p0_ack=1
p1_req, p1_addr, p1_we, p1_be, p1_wdata, p1_ack, p1_rdata: same as port 0
dram_ma  out  10  multiplexed row/column address
dram_d  inout  16  DRAM data; driven only during write data phase, else Z
dram_ras_n  out  1  row strobe
dram_ucas_n  out  1  upper-byte column strobe
dram_lcas_n  out  1  lower-byte column strobe
dram_we_n  out  1  write enable

Behaviour:
- Reset: state IDLE. Outputs take these values at the first edge with rst=1, including mid-access:
  - ras_n, ucas_n, lcas_n, we_n = 1; ma = 0; dram_d = Z.
  - acks = 0; rdata = 0.
  - Refresh counter reloaded; refresh pending cleared; rr_last = 1 (port 0 wins the first tie).
  - In-flight access is abandoned with no ack; requester keeps req high and is served after reset.
- Refresh counter:
  - Decrements when ref_en=1. At 0 it sets ref_pend and reloads.
  - ref_pend is sticky with no queueing: a further expiry while pending is lost.
  - ref_en=0 freezes the counter; an existing ref_pend is still serviced.
- Arbitration is evaluated in IDLE and in PRE. Priority order:
  1. ref_pend.
  2. If both ports request, the port != rr_last.
  3. The single requester.
  - rr_last is updated on grant.
  - Request inputs are sampled at the arbitration edge and latched for the whole access.
- Access states, one clock each, RAS -> COL -> CAS1 -> CAS2 -> PRE:
  - RAS: ras_n=0, ma=addr[9:0].
  - COL: ma=addr[19:10]. On a write: we_n=0 and dram_d driven with wdata.
  - CAS1: CAS strobes low.
    - Read: ucas_n=lcas_n=0 regardless of be.
    - Write: ucas_n=~be[1], lcas_n=~be[0].
  - CAS2: strobes held. On a read, dram_d is captured at the end of CAS2.
  - PRE: ras_n, cas_n, we_n = 1; dram_d = Z.
    - ackN=1 for one cycle; rdataN holds captured data from this cycle until the next read ack on that port.
    - A write ack leaves rdataN unchanged.
- Write with be=00: full timing and ack, CAS never asserted.
- Latency: ack arrives 5 clocks after the arbitration edge. Back-to-back accesses run every 5 clocks, since PRE arbitrates directly.
- Refresh states, one clock each, RF1 -> RF2 -> RF3 -> PRE:
  - RF1: ucas_n=lcas_n=0, ras_n=1, we_n=1.
  - RF2, RF3: ras_n=0 with CAS still low.
  - PRE: all strobes high, no ack.
  - ref_pend is cleared on entry to RF1.
- Invariants:
  - dram_d is never driven while we_n=1.
  - ras_n is never low in IDLE.
  - CAS never falls while ras_n=0 outside the access CAS1 state.
- Simultaneous events: refresh expiry coincident with a grant edge means ref_pend is set and the access proceeds. Refresh runs at that access's PRE.

Test Plan:
- Reset, then p0 writes addr=0x12345, data=0xBEEF, be=11 -> RAS ma=0x345, COL ma=0x048; ack at clock 5; DRAM model word 0x12345=0xBEEF.
- p1 reads 0x12345 after that write -> p1_ack at clock 5 with p1_rdata=0xBEEF; dram_d never driven by the controller.
- Write 0x00AA with be=01 to a word holding 0xBEEF -> only lcas_n falls; readback returns 0xBEAA. Write with be=00 -> ack, no CAS edge, data unchanged.
- p0_req and p1_req held high continuously -> grants alternate p0, p1, p0, …; each ack spaced 5 clocks apart.
- REF_PERIOD=20, idle ports, ref_en=1 -> CBR sequence every 20 clocks: CAS low one clock before RAS, no acks. With both ports busy, refresh is inserted at the first PRE after expiry.
- Assert rst during CAS2 of a read -> next edge has all strobes 1 and dram_d Z with no ack; after release, the held request completes normally.
